step_ram_loader: RTL and testbench

- Write-side counterpart to the step module's RAM read ports.
- Receives 32-bit words from the I/O side, one per INT strobe, and packs each pair into one 64-bit RAM entry.
- Writes the entries into consecutive step RAM addresses, which the step module later reads through RD1/RD2.
- Pulses Load_Done when the block is complete, so the coordinator can raise Process.

---
 rtl/step_pkg.sv | 17 +
 rtl/step_ram_loader.sv | 125 ++++++++++++
 tb/tb_step_ram_loader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/step_pkg.sv
// Constants shared by the step coordinator, step RAM and RAM loader,
// plus the loader's state encoding.
package step_pkg;
    localparam int RAM_ADDRESS_WIDTH = 13;
    localparam int IO_WIDTH          = 32;
    localparam int DATA_WIDTH        = 2 * IO_WIDTH;
    localparam int RAM_DEPTH         = 200;

    typedef enum logic [2:0] {
        LOADER_IDLE,
        GET_COUNT,
        GET_LOW,
        GET_HIGH,
        DONE,
        ERROR
    } loader_state_t;
endpackage

// File: rtl/step_ram_loader.sv
// Packs pairs of I/O words (low word first) into step RAM entries at
// consecutive addresses, then pulses Load_Done for the coordinator.
module step_ram_loader #(
    parameter int RAM_ADDRESS_WIDTH = step_pkg::RAM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH        = step_pkg::DATA_WIDTH,
    parameter int IO_WIDTH          = step_pkg::IO_WIDTH,
    parameter int RAM_DEPTH         = step_pkg::RAM_DEPTH,
    parameter int BASE_ADDRESS      = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Load_Start,
    input  logic                         INT,
    input  logic [IO_WIDTH-1:0]          IO_Data,
    output logic                         Busy,
    output logic                         Load_Done,
    output logic                         Load_Error,
    output logic                         Step_Memory_WR_Enable,
    output logic [RAM_ADDRESS_WIDTH-1:0] Step_RAM_WR_Address,
    output logic [DATA_WIDTH-1:0]        Step_RAM_WR_Data
);
    import step_pkg::*;

    localparam int AW = RAM_ADDRESS_WIDTH;
    // One extra bit so a count equal to the full RAM still compares correctly.
    localparam logic [AW:0] MAX_COUNT = (AW+1)'(RAM_DEPTH - BASE_ADDRESS);

    loader_state_t           state_q, state_d;
    logic [AW-1:0]           count_q, count_d;
    logic [AW-1:0]           index_q, index_d;
    logic [IO_WIDTH-1:0]     low_q, low_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    wr_en_q, wr_en_d;
    logic [AW-1:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    last_pair;

    assign last_pair = (index_q + AW'(1)) == count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= LOADER_IDLE;
            count_q   <= '0;
            index_q   <= '0;
            low_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            index_q   <= index_d;
            low_q     <= low_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOADER_IDLE: if (Load_Start) state_d = GET_COUNT;
            GET_COUNT: if (INT) begin
                if (IO_Data[AW-1:0] == '0)
                    state_d = DONE;
                else if ({1'b0, IO_Data[AW-1:0]} > MAX_COUNT)
                    state_d = ERROR;
                else
                    state_d = GET_LOW;
            end
            GET_LOW:     if (INT) state_d = GET_HIGH;
            GET_HIGH:    if (INT) state_d = last_pair ? DONE : GET_LOW;
            DONE, ERROR: state_d = LOADER_IDLE;
            default:     state_d = LOADER_IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        index_d   = index_q;
        low_d     = low_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        busy_d    = (state_d != LOADER_IDLE) && (state_d != ERROR);
        case (state_q)
            LOADER_IDLE: if (Load_Start) err_d = 1'b0;
            GET_COUNT: if (INT) begin
                count_d = IO_Data[AW-1:0];
                index_d = '0;
            end
            GET_LOW: if (INT) low_d = IO_Data;
            GET_HIGH: if (INT) begin
                wr_en_d   = 1'b1;
                wr_addr_d = AW'(BASE_ADDRESS) + index_q;
                wr_data_d = {IO_Data, low_q};
                index_d   = index_q + AW'(1);
                done_d    = last_pair;
            end
            // A non-empty load already pulsed alongside its last write.
            DONE:    done_d = (count_q == '0);
            default: ;
        endcase
        if (state_d == ERROR) err_d = 1'b1;
    end

    assign Busy                  = busy_q;
    assign Load_Done             = done_q;
    assign Load_Error            = err_q;
    assign Step_Memory_WR_Enable = wr_en_q;
    assign Step_RAM_WR_Address   = wr_addr_q;
    assign Step_RAM_WR_Data      = wr_data_q;

endmodule

// File: tb/tb_step_ram_loader.sv
// Scoreboard bench for step_ram_loader: expected RAM writes are queued as
// words are driven and checked as the write port fires.
module tb_step_ram_loader;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Load_Start = 1'b0;
    logic        INT = 1'b0;
    logic [31:0] IO_Data = '0;
    logic        Busy, Load_Done, Load_Error, WR_En;
    logic [12:0] WR_Addr;
    logic [63:0] WR_Data;

    step_ram_loader dut (
        .CLK(CLK), .RST(RST), .Load_Start(Load_Start), .INT(INT), .IO_Data(IO_Data),
        .Busy(Busy), .Load_Done(Load_Done), .Load_Error(Load_Error),
        .Step_Memory_WR_Enable(WR_En), .Step_RAM_WR_Address(WR_Addr),
        .Step_RAM_WR_Data(WR_Data)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [12:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  wr_cyc_log[$];
    int  n_cmp = 0, n_err = 0;
    int  cyc_n = 0, done_cnt = 0, wr_cnt = 0;
    int  last_done_cyc = -1, last_wr_cyc = -1, max_addr = -1;

    always @(posedge CLK) cyc_n <= cyc_n + 1;

    always @(negedge CLK) begin
        if (Load_Done) begin
            done_cnt++;
            last_done_cyc = cyc_n;
        end
        if (WR_En) begin
            wr_cnt++;
            last_wr_cyc = cyc_n;
            wr_cyc_log.push_back(cyc_n);
            if (int'(WR_Addr) > max_addr) max_addr = int'(WR_Addr);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write addr=%0d data=%h", WR_Addr, WR_Data);
            end else begin
                e = exp_q.pop_front();
                if (WR_Addr !== e.addr || WR_Data !== e.data) begin
                    n_err++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h",
                             WR_Addr, WR_Data, e.addr, e.data);
                end
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_int(input logic [31:0] w);
        INT = 1'b1;
        IO_Data = w;
        cyc();
        INT = 1'b0;
    endtask

    task automatic start();
        Load_Start = 1'b1;
        cyc();
        Load_Start = 1'b0;
    endtask

    task automatic push(input int addr, input logic [31:0] hi, input logic [31:0] lo);
        exp_q.push_back('{addr: 13'(addr), data: {hi, lo}});
    endtask

    task automatic test_reset();
        RST = 1'b1;
        cyc(2);
        n_cmp += 6;
        if (Busy !== 1'b0)       begin n_err++; $display("FAIL rst_busy got=%b want=0", Busy); end
        if (Load_Done !== 1'b0)  begin n_err++; $display("FAIL rst_done got=%b want=0", Load_Done); end
        if (Load_Error !== 1'b0) begin n_err++; $display("FAIL rst_err got=%b want=0", Load_Error); end
        if (WR_En !== 1'b0)      begin n_err++; $display("FAIL rst_wren got=%b want=0", WR_En); end
        if (WR_Addr !== '0)      begin n_err++; $display("FAIL rst_addr got=%0d want=0", WR_Addr); end
        if (WR_Data !== '0)      begin n_err++; $display("FAIL rst_data got=%h want=0", WR_Data); end
        RST = 1'b0;
        cyc();
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        start();
        send_int(32'd2);
        send_int(32'h1111_1111);
        send_int(32'h2222_2222); push(0, 32'h2222_2222, 32'h1111_1111);
        send_int(32'h3333_3333);
        send_int(32'h4444_4444); push(1, 32'h4444_4444, 32'h3333_3333);
        cyc(3);
        n_cmp += 4;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt - d0); end
        if (last_done_cyc != last_wr_cyc) begin
            n_err++; $display("FAIL basic_done_cycle got=%0d want=%0d", last_done_cyc, last_wr_cyc);
        end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL basic_missing_writes got=%0d want=0", exp_q.size()); end
        if (Busy !== 1'b0) begin n_err++; $display("FAIL basic_busy got=%b want=0", Busy); end
    endtask

    task automatic test_zero_count();
        int d0 = done_cnt, w0 = wr_cnt, int_cyc;
        start();
        send_int(32'd0);
        int_cyc = cyc_n - 1;
        cyc(4);
        n_cmp += 4;
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL zero_done_cnt got=%0d want=1", done_cnt - d0); end
        if (last_done_cyc != int_cyc + 2) begin
            n_err++; $display("FAIL zero_done_cycle got=%0d want=%0d", last_done_cyc, int_cyc + 2);
        end
        if (wr_cnt != w0) begin n_err++; $display("FAIL zero_writes got=%0d want=0", wr_cnt - w0); end
        if (Load_Error !== 1'b0) begin n_err++; $display("FAIL zero_err got=%b want=0", Load_Error); end
    endtask

    task automatic test_overflow();
        int w0 = wr_cnt, d0 = done_cnt;
        start();
        send_int(32'd201);
        cyc(3);
        n_cmp += 3;
        if (Load_Error !== 1'b1) begin n_err++; $display("FAIL ovf_err got=%b want=1", Load_Error); end
        if (Busy !== 1'b0) begin n_err++; $display("FAIL ovf_busy got=%b want=0", Busy); end
        if (done_cnt != d0) begin n_err++; $display("FAIL ovf_done got=%0d want=0", done_cnt - d0); end
        send_int(32'hDEAD_BEEF);
        cyc(5);
        n_cmp += 2;
        if (Load_Error !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%b want=1", Load_Error); end
        if (wr_cnt != w0) begin n_err++; $display("FAIL ovf_writes got=%0d want=0", wr_cnt - w0); end
        start();
        n_cmp++;
        if (Load_Error !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%b want=0", Load_Error); end
        send_int(32'd1);
        send_int(32'hAAAA_0001);
        send_int(32'hBBBB_0002); push(0, 32'hBBBB_0002, 32'hAAAA_0001);
        cyc(3);
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_followup got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_back_to_back_full();
        int w0 = wr_cnt, d0 = done_cnt, k0 = wr_cyc_log.size();
        logic [31:0] lo, hi;
        start();
        INT = 1'b1;
        IO_Data = 32'd200;
        cyc();
        for (int i = 0; i < 200; i++) begin
            lo = $urandom;
            hi = $urandom;
            push(i, hi, lo);
            IO_Data = lo;
            cyc();
            IO_Data = hi;
            cyc();
        end
        INT = 1'b0;
        cyc(4);
        n_cmp += 6;
        if (wr_cnt - w0 != 200) begin n_err++; $display("FAIL full_writes got=%0d want=200", wr_cnt - w0); end
        if (max_addr != 199) begin n_err++; $display("FAIL full_max_addr got=%0d want=199", max_addr); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL full_missing got=%0d want=0", exp_q.size()); end
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL full_done_cnt got=%0d want=1", done_cnt - d0); end
        if (last_done_cyc != last_wr_cyc) begin
            n_err++; $display("FAIL full_done_cycle got=%0d want=%0d", last_done_cyc, last_wr_cyc);
        end
        if (wr_cyc_log.size() < k0 + 200) begin
            n_err++; $display("FAIL full_spacing got=%0d writes want=200", wr_cyc_log.size() - k0);
        end else if (wr_cyc_log[k0 + 199] - wr_cyc_log[k0] != 398) begin
            n_err++; $display("FAIL full_spacing got=%0d want=398", wr_cyc_log[k0 + 199] - wr_cyc_log[k0]);
        end
    endtask

    task automatic test_reset_mid_load();
        int d0 = done_cnt, w0 = wr_cnt;
        start();
        send_int(32'd2);
        send_int(32'h5555_0000);
        send_int(32'h6666_0000); push(0, 32'h6666_0000, 32'h5555_0000);
        send_int(32'h7777_0000);
        RST = 1'b1;
        cyc();
        n_cmp += 4;
        if (Busy !== 1'b0)  begin n_err++; $display("FAIL mid_rst_busy got=%b want=0", Busy); end
        if (WR_En !== 1'b0) begin n_err++; $display("FAIL mid_rst_wren got=%b want=0", WR_En); end
        if (WR_Addr !== '0) begin n_err++; $display("FAIL mid_rst_addr got=%0d want=0", WR_Addr); end
        if (WR_Data !== '0) begin n_err++; $display("FAIL mid_rst_data got=%h want=0", WR_Data); end
        RST = 1'b0;
        send_int(32'h8888_0000);
        send_int(32'h9999_0000);
        cyc(3);
        n_cmp += 2;
        if (done_cnt != d0) begin n_err++; $display("FAIL mid_rst_done got=%0d want=0", done_cnt - d0); end
        if (wr_cnt - w0 != 1) begin n_err++; $display("FAIL mid_rst_writes got=%0d want=1", wr_cnt - w0); end
    endtask

    task automatic test_ignored_inputs();
        int d0 = done_cnt, w0 = wr_cnt;
        send_int(32'h0000_0002);
        send_int(32'hCAFE_0000);
        cyc(2);
        start();
        send_int(32'd2);
        send_int(32'h0101_0101);
        start();
        Load_Start = 1'b1;
        send_int(32'h0202_0202); push(0, 32'h0202_0202, 32'h0101_0101);
        Load_Start = 1'b0;
        send_int(32'h0303_0303);
        send_int(32'h0404_0404); push(1, 32'h0404_0404, 32'h0303_0303);
        cyc(3);
        n_cmp += 3;
        if (wr_cnt - w0 != 2) begin n_err++; $display("FAIL ign_writes got=%0d want=2", wr_cnt - w0); end
        if (done_cnt - d0 != 1) begin n_err++; $display("FAIL ign_done got=%0d want=1", done_cnt - d0); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL ign_missing got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_overflow();
        test_back_to_back_full();
        test_reset_mid_load();
        test_ignored_inputs();
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
